mux_share_arbiter: RTL and testbench

- Shares one 2:1 data mux between two valid/ready requesters and drives its select line.
- Arbitration is round-robin with a bounded burst. The chosen beat is captured in a one-entry registered output slot.
- Sits in front of any single-consumer resource; the consumer sees one merged stream tagged with the source index.
- Sustains 1 beat/cycle with 1-cycle latency.

---
 rtl/mux_share_arbiter_pkg.sv | 11 +
 rtl/mux_share_arbiter_if.sv | 36 +++
 rtl/mux_share_arbiter_rr_burst_grant.sv | 58 +++++
 rtl/mux_share_arbiter.sv | 63 ++++++
 tb/tb_mux_share_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_share_arbiter_pkg.sv
// Shared constants for the mux_share_arbiter slice.
// Source indices and default width / burst length.
package mux_share_arbiter_pkg;

   localparam logic SRC0 = 1'b0;
   localparam logic SRC1 = 1'b1;

   localparam int W_DEF     = 8;
   localparam int BURST_DEF = 2;

endpackage

// File: rtl/mux_share_arbiter_if.sv
// Two requester valid/ready channels plus one merged output channel.
// slave: arbiter side; master: requester/consumer side.
interface mux_share_arbiter_if
   import mux_share_arbiter_pkg::*;
#(
   parameter int W = W_DEF
);

   logic         s_valid0;
   logic [W-1:0] s_data0;
   logic         s_ready0;
   logic         s_valid1;
   logic [W-1:0] s_data1;
   logic         s_ready1;
   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] m_data;
   logic         m_src;

   modport slave (
      input  s_valid0, s_data0,
      input  s_valid1, s_data1,
      input  m_ready,
      output s_ready0, s_ready1,
      output m_valid, m_data, m_src
   );

   modport master (
      output s_valid0, s_data0,
      output s_valid1, s_data1,
      output m_ready,
      input  s_ready0, s_ready1,
      input  m_valid, m_data, m_src
   );

endinterface

// File: rtl/mux_share_arbiter_rr_burst_grant.sv
// Round-robin grant with bounded burst; owns the owner/cnt state.
// Ports: i_clk, i_rst, i_slot_free, i_valid0/1 in; o_gnt_vld, o_gnt out.
module rr_burst_grant
   import mux_share_arbiter_pkg::*;
#(
   parameter int BURST = BURST_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_slot_free,
   input  logic i_valid0,
   input  logic i_valid1,
   output logic o_gnt_vld,
   output logic o_gnt
);

   localparam int CW = $clog2(BURST + 1);
   localparam logic [CW-1:0] C_MAX = CW'(BURST);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   logic          r_owner;
   logic [CW-1:0] r_cnt;
   logic          w_sat;
   logic          w_gnt;
   logic          w_gnt_vld;

   assign w_sat = (r_cnt == C_MAX);

   // Under contention the owner keeps the grant until its burst is spent.
   always_comb begin
      w_gnt = SRC0;
      if (i_valid0 && i_valid1)
         w_gnt = w_sat ? ~r_owner : r_owner;
      else if (i_valid1)
         w_gnt = SRC1;
   end

   assign w_gnt_vld = !i_rst && i_slot_free
                   && (i_valid0 || i_valid1);
   assign o_gnt_vld = w_gnt_vld;
   assign o_gnt     = w_gnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_owner <= SRC0;
         r_cnt   <= '0;
      end else if (w_gnt_vld) begin
         if (w_gnt == r_owner) begin
            if (!w_sat)
               r_cnt <= r_cnt + C_ONE;
         end else begin
            r_owner <= w_gnt;
            r_cnt   <= C_ONE;
         end
      end
   end

endmodule

// File: rtl/mux_share_arbiter.sv
// Shares a 2:1 data mux between two requesters into one registered slot.
// Ports: CLK, RST (sync, active-high); bus = slave side of the interface.
module mux_share_arbiter
   import mux_share_arbiter_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int BURST = BURST_DEF
) (
   input  logic CLK,
   input  logic RST,
   mux_share_arbiter_if.slave bus
);

   logic         r_valid;
   logic [W-1:0] r_data;
   logic         r_src;
   logic         w_slot_free;
   logic         w_gnt_vld;
   logic         w_gnt;
   logic [W-1:0] w_mux;

   // A full slot may be refilled in the cycle it drains.
   assign w_slot_free = !r_valid || bus.m_ready;

   rr_burst_grant #(
      .BURST (BURST)
   ) u_grant (
      .i_clk       (CLK),
      .i_rst       (RST),
      .i_slot_free (w_slot_free),
      .i_valid0    (bus.s_valid0),
      .i_valid1    (bus.s_valid1),
      .o_gnt_vld   (w_gnt_vld),
      .o_gnt       (w_gnt)
   );

   assign w_mux = (w_gnt == SRC1) ? bus.s_data1
                                  : bus.s_data0;

   assign bus.s_ready0 = w_gnt_vld && (w_gnt == SRC0);
   assign bus.s_ready1 = w_gnt_vld && (w_gnt == SRC1);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_src   <= SRC0;
      end else if (w_slot_free) begin
         if (w_gnt_vld) begin
            r_valid <= 1'b1;
            r_data  <= w_mux;
            r_src   <= w_gnt;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.m_valid = r_valid;
   assign bus.m_data  = r_data;
   assign bus.m_src   = r_src;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Scoreboard bench for mux_share_arbiter (W=8, BURST=2).
// Directed sources feed queues; a monitor checks every output beat.
module tb_mux_share_arbiter;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   always #5 CLK = ~CLK;

   mux_share_arbiter_if #(.W(8)) bus ();

   mux_share_arbiter #(
      .W     (8),
      .BURST (2)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [8:0] exp_q[$];
   logic       en0 = 1'b0;
   logic       en1 = 1'b0;
   logic       hs0;
   logic       hs1;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   task automatic push(input logic s, input logic [7:0] d);
      exp_q.push_back({s, d});
   endtask

   // Present inputs at the falling edge, note handshakes just after.
   task automatic drive();
      @(negedge CLK);
      bus.s_valid0 = en0 && (q0.size() > 0);
      bus.s_data0  = (q0.size() > 0) ? q0[0] : 8'h00;
      bus.s_valid1 = en1 && (q1.size() > 0);
      bus.s_data1  = (q1.size() > 0) ? q1[0] : 8'h00;
      #1;
      hs0 = bus.s_valid0 && bus.s_ready0;
      hs1 = bus.s_valid1 && bus.s_ready1;
      total++;
      if (bus.s_ready0 && bus.s_ready1) begin
         bad++;
         $display("FAIL ready_onehot: got 11 want <=1 high");
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      if (hs0) void'(q0.pop_front());
      if (hs1) void'(q1.pop_front());
   endtask

   task automatic do_reset();
      RST = 1'b1;
      en0 = 1'b0;
      en1 = 1'b0;
      q0.delete();
      q1.delete();
      drive();
      tick();
      exp_q.delete();
      RST = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         drive();
         tick();
         n++;
      end
      chk({nm, "_drain"}, exp_q.size(), 0);
   endtask

   // Monitor: every transferred output beat must match the queue head.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge CLK);
         #2;
         if (!RST && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL beat_unexp: got %h want none",
                        {bus.m_src, bus.m_data});
            end else begin
               e = exp_q.pop_front();
               chk("beat", {23'd0, bus.m_src, bus.m_data},
                   {23'd0, e});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d2 [3];
      d2 = '{8'h11, 8'h22, 8'h33};
      bus.s_valid0 = 1'b0;
      bus.s_data0  = 8'h00;
      bus.s_valid1 = 1'b0;
      bus.s_data1  = 8'h00;
      bus.m_ready  = 1'b1;
      hs0 = 1'b0;
      hs1 = 1'b0;

      // 1: reset with both requesters valid, then idle
      RST = 1'b1;
      q0 = '{8'hEE};
      q1 = '{8'hDD};
      en0 = 1'b1;
      en1 = 1'b1;
      drive();
      tick();
      drive();
      tick();
      drive();
      chk("rst_rdy0", bus.s_ready0, 0);
      chk("rst_rdy1", bus.s_ready1, 0);
      chk("rst_mvalid", bus.m_valid, 0);
      chk("rst_mdata", bus.m_data, 0);
      chk("rst_msrc", bus.m_src, 0);
      tick();
      en0 = 1'b0;
      en1 = 1'b0;
      q0.delete();
      q1.delete();
      RST = 1'b0;
      drive();
      chk("idle_rdy0", bus.s_ready0, 0);
      chk("idle_rdy1", bus.s_ready1, 0);
      tick();
      drive();
      chk("idle_mvalid", bus.m_valid, 0);
      tick();

      // 2: single stream from requester 0
      do_reset();
      q0 = '{8'h11, 8'h22, 8'h33};
      push(1'b0, 8'h11);
      push(1'b0, 8'h22);
      push(1'b0, 8'h33);
      en0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive();
         chk("s2_rdy0", bus.s_ready0, 1);
         chk("s2_rdy1", bus.s_ready1, 0);
         if (i > 0) begin
            chk("s2_lat_v", bus.m_valid, 1);
            chk("s2_lat_d", bus.m_data, d2[i-1]);
         end
         tick();
      end
      wait_drain("s2");

      // 3: contention, burst of two each
      do_reset();
      q0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      q1 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
      push(1'b0, 8'hA0);
      push(1'b0, 8'hA1);
      push(1'b1, 8'hB0);
      push(1'b1, 8'hB1);
      push(1'b0, 8'hA2);
      push(1'b0, 8'hA3);
      push(1'b1, 8'hB2);
      push(1'b1, 8'hB3);
      en0 = 1'b1;
      en1 = 1'b1;
      wait_drain("s3");

      // 4: backpressure hold, then drain and refill together
      do_reset();
      bus.m_ready = 1'b0;
      q0 = '{8'h5C};
      push(1'b0, 8'h5C);
      en0 = 1'b1;
      en1 = 1'b1;
      drive();
      tick();
      q0.push_back(8'hC1);
      q0.push_back(8'hC2);
      q1.push_back(8'hD1);
      push(1'b0, 8'hC1);
      push(1'b1, 8'hD1);
      push(1'b0, 8'hC2);
      for (int i = 0; i < 3; i++) begin
         drive();
         chk("bp_mvalid", bus.m_valid, 1);
         chk("bp_mdata", bus.m_data, 8'h5C);
         chk("bp_rdy0", bus.s_ready0, 0);
         chk("bp_rdy1", bus.s_ready1, 0);
         tick();
      end
      bus.m_ready = 1'b1;
      drive();
      chk("bp_refill0", bus.s_ready0, 1);
      chk("bp_refill1", bus.s_ready1, 0);
      tick();
      drive();
      chk("bp_nobub_v", bus.m_valid, 1);
      chk("bp_nobub_d", bus.m_data, 8'hC1);
      tick();
      wait_drain("s4");

      // 5: late contender after a saturated lone burst
      do_reset();
      q0 = '{8'h40, 8'h41, 8'h42, 8'h43};
      push(1'b0, 8'h40);
      push(1'b0, 8'h41);
      push(1'b0, 8'h42);
      push(1'b0, 8'h43);
      push(1'b1, 8'h50);
      push(1'b0, 8'h44);
      en0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive();
         chk("s5_lone", bus.s_ready0, 1);
         tick();
      end
      q0.push_back(8'h44);
      q1.push_back(8'h50);
      en1 = 1'b1;
      drive();
      chk("s5_late1", bus.s_ready1, 1);
      chk("s5_late0", bus.s_ready0, 0);
      tick();
      wait_drain("s5");

      // 6: reset while a beat from requester 1 is held
      do_reset();
      bus.m_ready = 1'b0;
      q1 = '{8'h77};
      push(1'b1, 8'h77);
      en1 = 1'b1;
      drive();
      tick();
      drive();
      chk("s6_held_v", bus.m_valid, 1);
      chk("s6_held_d", bus.m_data, 8'h77);
      tick();
      RST = 1'b1;
      drive();
      tick();
      exp_q.delete();
      RST = 1'b0;
      drive();
      chk("s6_rst_v", bus.m_valid, 0);
      chk("s6_rst_d", bus.m_data, 0);
      tick();
      bus.m_ready = 1'b1;
      q0 = '{8'h61};
      q1 = '{8'h62};
      push(1'b0, 8'h61);
      push(1'b1, 8'h62);
      en0 = 1'b1;
      en1 = 1'b1;
      drive();
      chk("s6_tie0", bus.s_ready0, 1);
      chk("s6_tie1", bus.s_ready1, 0);
      tick();
      wait_drain("s6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
